// File: rtl/fetcher.sv
// Instruction-fetch stage: owns the PC, issues one icache request at a time, predicts the next PC
// for JAL/B-type and buffers fetched entries in a show-ahead FIFO for the decoder.
module fetcher #(
   parameter int BP_TAG_W = 8,
   parameter int IQ_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   output logic                out_icache_valid,
   output logic [31:0]         out_icache_pc,
   input  logic                in_icache_valid,
   input  logic [31:0]         in_icache_inst,
   output logic [BP_TAG_W-1:0] out_bp_tag,
   input  logic                in_bp_jump,
   output logic                out_dec_valid,
   output logic [31:0]         out_dec_inst,
   output logic [31:0]         out_dec_pc,
   output logic                out_dec_pred_jump,
   input  logic                in_dec_ready,
   input  logic                in_rob_flush,
   input  logic [31:0]         in_rob_target_pc
);
   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]         iq_inst_q [IQ_DEPTH];
   logic [31:0]         iq_pc_q   [IQ_DEPTH];
   logic [IQ_DEPTH-1:0] iq_pred_q;

   logic        flush, push, pop, full, nonempty;
   logic        pred;
   logic [31:0] next_pc;

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   assign nonempty = (cnt_q != '0);
   assign full     = (cnt_q == CNT_W'(IQ_DEPTH));
   assign flush    = rdy & in_rob_flush;
   assign push     = rdy & ~in_rob_flush & (state_q == WAIT) & in_icache_valid;
   assign pop      = rdy & ~in_rob_flush & nonempty & in_dec_ready;

   always_comb begin
      pred    = 1'b0;
      next_pc = pc_q + 32'd4;
      case (in_icache_inst[6:0])
         OP_JAL: begin
            pred    = 1'b1;
            next_pc = pc_q + imm_j(in_icache_inst);
         end
         OP_BR: begin
            pred = in_bp_jump;
            if (in_bp_jump) next_pc = pc_q + imm_b(in_icache_inst);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A flush with no same-cycle response leaves one answer outstanding, which DROP swallows.
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            IDLE:    if (!in_rob_flush && !full) state_d = WAIT;
            WAIT: begin
               if (in_icache_valid)   state_d = IDLE;
               else if (in_rob_flush) state_d = DROP;
            end
            DROP:    if (in_icache_valid) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      out_icache_valid  = (state_q == WAIT);
      out_icache_pc     = pc_q;
      out_bp_tag        = pc_q[BP_TAG_W+1:2];
      out_dec_valid     = nonempty;
      out_dec_inst      = '0;
      out_dec_pc        = '0;
      out_dec_pred_jump = 1'b0;
      if (nonempty) begin
         out_dec_inst      = iq_inst_q[head_q];
         out_dec_pc        = iq_pc_q[head_q];
         out_dec_pred_jump = iq_pred_q[head_q];
      end
   end

   always_comb begin
      pc_d   = pc_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush) begin
         pc_d   = in_rob_target_pc;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            pc_d   = next_pc;
            tail_d = tail_q + 1'b1;
         end
         if (pop) head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage carries no reset; visibility is governed by cnt_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         iq_inst_q[tail_q] <= in_icache_inst;
         iq_pc_q[tail_q]   <= pc_q;
         iq_pred_q[tail_q] <= pred;
      end
   end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: directed fetch streams, FIFO backpressure, flush and reset cases.
module tb_fetcher;
   localparam int          BP_TAG_W = 8;
   localparam int          IQ_DEPTH = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] BR_M8    = 32'hFE00_0CE3;
   localparam logic [31:0] JAL_P8   = 32'h0080_006F;
   localparam logic [31:0] JALR     = 32'h0000_80E7;

   logic                clk, rst, rdy;
   logic                out_icache_valid;
   logic [31:0]         out_icache_pc;
   logic                in_icache_valid;
   logic [31:0]         in_icache_inst;
   logic [BP_TAG_W-1:0] out_bp_tag;
   logic                in_bp_jump;
   logic                out_dec_valid;
   logic [31:0]         out_dec_inst;
   logic [31:0]         out_dec_pc;
   logic                out_dec_pred_jump;
   logic                in_dec_ready;
   logic                in_rob_flush;
   logic [31:0]         in_rob_target_pc;

   fetcher #(.BP_TAG_W(BP_TAG_W), .IQ_DEPTH(IQ_DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .out_icache_valid(out_icache_valid), .out_icache_pc(out_icache_pc),
      .in_icache_valid(in_icache_valid), .in_icache_inst(in_icache_inst),
      .out_bp_tag(out_bp_tag), .in_bp_jump(in_bp_jump),
      .out_dec_valid(out_dec_valid), .out_dec_inst(out_dec_inst),
      .out_dec_pc(out_dec_pc), .out_dec_pred_jump(out_dec_pred_jump),
      .in_dec_ready(in_dec_ready), .in_rob_flush(in_rob_flush),
      .in_rob_target_pc(in_rob_target_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        bp;
      logic        pred;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          req_cnt = 0;
   bit          req_seen = 0;
   logic [31:0] exp_req [$];
   vec_t        exp_dec [$];
   logic [31:0] mon_e;
   vec_t        mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares each new request and each accepted head against the queues.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         req_seen = 0;
      end else begin
         if (out_icache_valid && !req_seen) begin
            req_cnt++;
            if (exp_req.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req actual=%h required=none", out_icache_pc);
            end else begin
               mon_e = exp_req.pop_front();
               check("req_pc", out_icache_pc, mon_e);
               check("req_tag", 32'(out_bp_tag), 32'(mon_e[9:2]));
            end
         end
         req_seen = out_icache_valid;
         if (rdy && out_dec_valid && in_dec_ready && !in_rob_flush) begin
            if (exp_dec.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dec actual=%h required=none", out_dec_pc);
            end else begin
               mon_d = exp_dec.pop_front();
               check("dec_pc", out_dec_pc, mon_d.pc);
               check("dec_inst", out_dec_inst, mon_d.inst);
               check("dec_pred", 32'(out_dec_pred_jump), 32'(mon_d.pred));
            end
         end
      end
   end

   task automatic wait_req(input string name);
      int n = 0;
      while (!out_icache_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_icache_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_request required=request", name);
      end
   endtask

   task automatic serve(input logic [31:0] inst, input logic bp, input int lat);
      wait_req("serve");
      repeat (lat) @(negedge clk);
      in_icache_valid = 1'b1;
      in_icache_inst  = inst;
      in_bp_jump      = bp;
      @(negedge clk);
      in_icache_valid = 1'b0;
      in_icache_inst  = '0;
      in_bp_jump      = 1'b0;
   endtask

   task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst,
                               input logic bp, input logic pred);
      vec_t v;
      v = '{pc: pc, inst: inst, bp: bp, pred: pred};
      exp_req.push_back(pc);
      exp_dec.push_back(v);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_icache_valid"}, 32'(out_icache_valid), 32'd0);
      check({tag, "_icache_pc"}, out_icache_pc, 32'd0);
      check({tag, "_bp_tag"}, 32'(out_bp_tag), 32'd0);
      check({tag, "_dec_valid"}, 32'(out_dec_valid), 32'd0);
      check({tag, "_dec_inst"}, out_dec_inst, 32'd0);
      check({tag, "_dec_pc"}, out_dec_pc, 32'd0);
      check({tag, "_dec_pred"}, 32'(out_dec_pred_jump), 32'd0);
   endtask

   vec_t stream [13] = '{
      '{32'h00, NOP, 1'b0, 1'b0}, '{32'h04, NOP, 1'b0, 1'b0},
      '{32'h08, NOP, 1'b0, 1'b0}, '{32'h0C, NOP, 1'b0, 1'b0},
      '{32'h10, BR_M8, 1'b1, 1'b1}, '{32'h08, NOP, 1'b0, 1'b0},
      '{32'h0C, NOP, 1'b0, 1'b0}, '{32'h10, BR_M8, 1'b0, 1'b0},
      '{32'h14, NOP, 1'b0, 1'b0}, '{32'h18, NOP, 1'b0, 1'b0},
      '{32'h1C, NOP, 1'b0, 1'b0}, '{32'h20, JAL_P8, 1'b0, 1'b1},
      '{32'h28, JALR, 1'b1, 1'b0}
   };

   initial begin
      int hi;
      int r0;
      rst = 1'b1; rdy = 1'b1;
      in_icache_valid = 1'b0; in_icache_inst = '0; in_bp_jump = 1'b0;
      in_dec_ready = 1'b0; in_rob_flush = 1'b0; in_rob_target_pc = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      in_dec_ready = 1'b1;

      // sequential NOPs, B-type taken/not-taken, JAL, JALR
      foreach (stream[i]) begin
         expect_fetch(stream[i].pc, stream[i].inst, stream[i].bp, stream[i].pred);
         serve(stream[i].inst, stream[i].bp, 0);
      end

      // decoder stalled: FIFO fills, then one pop releases exactly one fetch
      in_dec_ready = 1'b0;
      expect_fetch(32'h2C, NOP, 1'b0, 1'b0);
      expect_fetch(32'h30, NOP, 1'b0, 1'b0);
      expect_fetch(32'h34, NOP, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) serve(NOP, 1'b0, 0);
      hi = 0;
      repeat (6) begin
         @(negedge clk);
         hi += int'(out_icache_valid);
      end
      check("full_no_req", 32'(hi), 32'd0);
      check("full_head_pc", out_dec_pc, 32'h28);
      r0 = req_cnt;
      expect_fetch(32'h38, NOP, 1'b0, 1'b0);
      in_dec_ready = 1'b1;
      @(negedge clk);
      in_dec_ready = 1'b0;
      serve(NOP, 1'b0, 0);
      hi = 0;
      repeat (6) begin
         @(negedge clk);
         hi += int'(out_icache_valid);
      end
      check("refull_no_req", 32'(hi), 32'd0);
      check("one_more_fetch", 32'(req_cnt - r0), 32'd1);

      // flush while WAIT, response arrives later and is dropped
      exp_req.push_back(32'h3C);
      in_dec_ready = 1'b1;
      wait_req("flush_wait");
      in_rob_flush = 1'b1;
      in_rob_target_pc = 32'h100;
      exp_dec.delete();
      @(negedge clk);
      in_rob_flush = 1'b0;
      check("drop_pc", out_icache_pc, 32'h100);
      check("drop_fifo_empty", 32'(out_dec_valid), 32'd0);
      check("drop_no_req", 32'(out_icache_valid), 32'd0);
      @(negedge clk);
      check("drop_no_req2", 32'(out_icache_valid), 32'd0);
      expect_fetch(32'h100, NOP, 1'b0, 1'b0);
      in_icache_valid = 1'b1;
      in_icache_inst  = JAL_P8;
      @(negedge clk);
      in_icache_valid = 1'b0;
      in_icache_inst  = '0;
      check("dropped_resp_fifo", 32'(out_dec_valid), 32'd0);
      check("dropped_resp_pc", out_icache_pc, 32'h100);
      serve(NOP, 1'b0, 0);

      // flush with same-cycle response, then reset mid-WAIT
      exp_req.push_back(32'h104);
      wait_req("flush_resp");
      in_icache_valid = 1'b1;
      in_icache_inst  = NOP;
      in_rob_flush = 1'b1;
      in_rob_target_pc = 32'h200;
      @(negedge clk);
      in_icache_valid = 1'b0;
      in_rob_flush = 1'b0;
      check("flush_resp_fifo", 32'(out_dec_valid), 32'd0);
      check("flush_resp_pc", out_icache_pc, 32'h200);
      check("flush_resp_idle", 32'(out_icache_valid), 32'd0);
      in_dec_ready = 1'b0;
      expect_fetch(32'h200, NOP, 1'b0, 1'b0);
      serve(NOP, 1'b0, 0);
      exp_req.push_back(32'h204);
      wait_req("pre_rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_dec.delete();
      repeat (2) @(negedge clk);
      exp_req.push_back(32'h0);
      rst = 1'b0;

      // rdy low freezes everything, including response, flush and pop
      wait_req("rdy_low");
      rdy = 1'b0;
      in_icache_valid = 1'b1;
      in_icache_inst  = JAL_P8;
      in_rob_flush = 1'b1;
      in_rob_target_pc = 32'h300;
      in_dec_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("frz_valid", 32'(out_icache_valid), 32'd1);
         check("frz_pc", out_icache_pc, 32'h0);
         check("frz_dec_valid", 32'(out_dec_valid), 32'd0);
      end
      rdy = 1'b1;
      in_icache_valid = 1'b0;
      in_icache_inst  = '0;
      in_rob_flush = 1'b0;
      exp_dec.push_back('{pc: 32'h0, inst: NOP, bp: 1'b0, pred: 1'b0});
      serve(NOP, 1'b0, 0);
      expect_fetch(32'h4, NOP, 1'b0, 1'b0);
      serve(NOP, 1'b0, 0);
      exp_req.push_back(32'h8);
      repeat (4) @(negedge clk);
      check("req_queue_drained", 32'(exp_req.size()), 32'd0);
      check("dec_queue_drained", 32'(exp_dec.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
